tdm_selector41: RTL
===================

# tdm_selector41

Four-channel time-division multiplexer, the transmit end for the existing 1-to-4 de-selector. Once per frame it captures four parallel channel words. It then drives them one slot at a time onto a single data line, together with the 2-bit select code {oS1,oS0}. The de-selector on the receive side uses that code to route each word back to its channel. A frame-start strobe and a valid flag let the receiver, or a bench, align to the slot sequence.

## Interface
Parameters:
- DATA_W, default 1: width of each channel word and of oZ.
- SLOT_CYCLES, default 4: clock cycles per slot; legal range 1 to 255.

Ports:
- iClk  in  1  system clock; all state updates on the rising edge.
- iRst  in  1  reset, asynchronous and active-high; one clock domain.
- iEn  in  1  run request, sampled at frame boundaries.
- iC0  in  DATA_W  channel 0 word.
- iC1  in  DATA_W  channel 1 word.
- iC2  in  DATA_W  channel 2 word.
- iC3  in  DATA_W  channel 3 word.
- oZ  out  DATA_W  multiplexed data for the current slot.
- oS0  out  1  slot select, bit 0.
- oS1  out  1  slot select, bit 1.
- oFrame  out  1  high on the first cycle of slot 0 only.
- oValid  out  1  high while oZ, oS1 and oS0 carry a slot.

## Operation
- FSM states:
  - IDLE: outputs held at their reset values.
  - RUN: slots are being driven.
- IDLE to RUN: on an edge with iEn=1.
  - iC0..iC3 are captured into four holding registers on that edge.
  - The slot counter is set to 0 and the dwell counter to 0.
- In RUN:
  - oZ = hold[slot].
  - {oS1,oS0} = slot, binary: 0=C0, 1=C1, 2=C2, 3=C3.
  - oValid = 1.
- Dwell counter counts 0 to SLOT_CYCLES-1; at SLOT_CYCLES-1 it wraps and the slot counter increments.
- End of frame is slot 3 with dwell at SLOT_CYCLES-1:
  - iEn=1: recapture iC0..iC3 on the same edge and restart at slot 0 with no gap cycle; oFrame=1 again.
  - iEn=0: go to IDLE.
- iEn dropping mid-frame has no effect; the frame always completes all four slots.
- iC0..iC3 changing mid-frame has no effect; the held values are used until the next capture.
- SLOT_CYCLES=1: each slot lasts one cycle; oFrame is high one cycle in four.
- Reset values, applied asynchronously at any time including mid-frame:
  - Outputs: oZ=0, oS0=0, oS1=0, oFrame=0, oValid=0.
  - Internal: state IDLE, holding registers 0.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Start latency: iEn=1 sampled on edge k in IDLE gives oValid=1, oFrame=1, slot 0 in the cycle after edge k.
- Frame period: exactly 4*SLOT_CYCLES cycles; back-to-back frames are contiguous.
- Capture point: only the edge that starts a frame; samples taken at any other time are ignored.
- Return to idle: oValid falls on the edge that ends slot 3 when iEn=0; oZ, oS0 and oS1 return to 0 on that same edge.
- Reset release: the first edge after iRst falls may start a frame if iEn=1.

## Structure
- Shared package:
  - Slot code constants SLOT_C0..SLOT_C3 (2-bit), common with the de-selector.
  - FSM state encoding IDLE/RUN.
- Sub-module tdm_slot_counter:
  - Dwell counter plus 2-bit slot counter, with parameter SLOT_CYCLES.
  - Outputs slot, first_cycle and frame_end.
- Top level holds the FSM, the four holding registers, the output mux and the output registers.

## Test plan
- Reset and idle: assert iRst mid-run, then hold iEn=0 for 20 cycles -> every output stays 0 throughout.
- Single frame (DATA_W=4, SLOT_CYCLES=2): iC0..iC3 = 4'hA, 4'h5, 4'hC, 4'h3; pulse iEn for 1 cycle ->
  - oZ sequence A,A,5,5,C,C,3,3.
  - {oS1,oS0} sequence 0,0,1,1,2,2,3,3.
  - oFrame high for cycle 1 only.
  - Then oValid=0.
- Mid-frame input change: change iC2 to 4'hF during slot 1 -> slot 2 still outputs 4'hC; the next frame outputs 4'hF.
- Continuous run with iEn held high for 3 frames:
  - No gap between frames.
  - oFrame pulses every 8 cycles.
  - Inputs are recaptured at each boundary.
- Reset mid-frame: assert iRst during slot 2 -> all outputs are 0 immediately, without waiting for a clock edge; after release with iEn=1, the next frame starts at slot 0.
- Loopback: connect oZ, oS0 and oS1 to the de-selector, with SLOT_CYCLES=1 and DATA_W=1, and inputs 1,0,1,1 -> the de-selector outputs oZ0..oZ3 match those inputs in their respective slots.

Source files
------------

// File: rtl/tdm_selector41_pkg.sv
// rtl/tdm_selector41_pkg.sv - shared slot codes and FSM encoding for the TDM selector/de-selector pair
//
// Purpose: constants common to the transmit selector and the receive de-selector.
// Contents:
//   SLOT_C0..SLOT_C3 : 2-bit select codes {S1,S0} for channel words C0..C3
//   tdmState_t       : selector FSM state encoding (IDLE, RUN)
package tdm_selector41_pkg;

    localparam logic [1:0] SLOT_C0 = 2'd0;
    localparam logic [1:0] SLOT_C1 = 2'd1;
    localparam logic [1:0] SLOT_C2 = 2'd2;
    localparam logic [1:0] SLOT_C3 = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdmState_t;

endpackage

// File: rtl/tdm_selector41_slot_counter.sv
// rtl/tdm_selector41_slot_counter.sv - dwell counter plus 2-bit slot counter for the TDM selector
//
// Purpose: sequences four slots of SLOT_CYCLES clocks each.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   restart      : force slot 0 / dwell 0 on this edge (frame start)
//   advance      : count one cycle on this edge
//   slot         : slot the counter enters on the coming edge
//   first_cycle  : the coming edge enters slot 0, dwell 0
//   frame_end    : the current cycle is the last cycle of slot 3
// slot and first_cycle look one edge ahead so the parent can load its output
// registers with the values of the cycle being entered.
module tdm_slot_counter
    import tdm_selector41_pkg::*;
#(
    parameter int SLOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       advance,
    output logic [1:0] slot,
    output logic       first_cycle,
    output logic       frame_end
);

    localparam int DWELL_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SLOT_CYCLES - 1);

    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwellNext;
    logic [1:0]         slotCur;
    logic [1:0]         slotNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            slotCur <= SLOT_C0;
        end else begin
            dwell   <= dwellNext;
            slotCur <= slotNext;
        end
    end

    always_comb begin
        dwellNext = dwell;
        slotNext  = slotCur;
        if (restart) begin
            dwellNext = '0;
            slotNext  = SLOT_C0;
        end else if (advance) begin
            if (dwell == DWELL_LAST) begin
                dwellNext = '0;
                // Slot 3 wraps to slot 0, leaving the counter clean for idle.
                slotNext  = slotCur + 2'd1;
            end else begin
                dwellNext = dwell + 1'b1;
            end
        end
    end

    assign slot        = slotNext;
    assign first_cycle = (slotNext == SLOT_C0) && (dwellNext == '0);
    assign frame_end   = (slotCur == SLOT_C3) && (dwell == DWELL_LAST);

endmodule

// File: rtl/tdm_selector41.sv
// rtl/tdm_selector41.sv - four-channel time-division multiplexer (transmit end of the 1-to-4 de-selector)
//
// Purpose: captures four channel words at each frame start and drives them one
// slot at a time on oZ with select code {oS1,oS0}.
// Ports:
//   iClk, iRst        : clock, asynchronous active-high reset
//   iEn               : run request, sampled only at frame boundaries
//   iC0..iC3          : channel words (DATA_W bits)
//   oZ                : word for the current slot
//   oS1, oS0          : slot select code
//   oFrame            : first cycle of slot 0
//   oValid            : a slot is being driven
module tdm_selector41
    import tdm_selector41_pkg::*;
#(
    parameter int DATA_W      = 1,
    parameter int SLOT_CYCLES = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic [DATA_W-1:0] iC0,
    input  logic [DATA_W-1:0] iC1,
    input  logic [DATA_W-1:0] iC2,
    input  logic [DATA_W-1:0] iC3,
    output logic [DATA_W-1:0] oZ,
    output logic              oS0,
    output logic              oS1,
    output logic              oFrame,
    output logic              oValid
);

    tdmState_t         state;
    tdmState_t         stateNext;
    logic              restart;
    logic              advance;
    logic [1:0]        slot;
    logic              firstCycle;
    logic              frameEnd;

    logic [DATA_W-1:0] hold     [4];
    logic [DATA_W-1:0] holdNext [4];

    logic [DATA_W-1:0] zNext;
    logic [1:0]        selNext;
    logic              frameNext;
    logic              validNext;

    tdm_slot_counter #(
        .SLOT_CYCLES(SLOT_CYCLES)
    ) u_slot_counter (
        .clk        (iClk),
        .rst        (iRst),
        .restart    (restart),
        .advance    (advance),
        .slot       (slot),
        .first_cycle(firstCycle),
        .frame_end  (frameEnd)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // iEn is only looked at when starting from idle or on the last cycle of a
    // frame; a restart at frame end gives contiguous frames with no gap cycle.
    always_comb begin
        stateNext = state;
        restart   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (iEn) begin
                    stateNext = RUN;
                    restart   = 1'b1;
                end
            end
            RUN: begin
                advance = 1'b1;
                if (frameEnd) begin
                    if (iEn) begin
                        restart = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Channel words are captured only on a frame-start edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            holdNext[i] = hold[i];
        end
        if (restart) begin
            holdNext[0] = iC0;
            holdNext[1] = iC1;
            holdNext[2] = iC2;
            holdNext[3] = iC3;
        end
    end

    // Output registers are loaded with the slot being entered, so the word
    // captured on a frame-start edge appears in the very next cycle.
    always_comb begin
        validNext = (stateNext == RUN);
        zNext     = '0;
        selNext   = SLOT_C0;
        frameNext = 1'b0;
        if (validNext) begin
            zNext     = holdNext[slot];
            selNext   = slot;
            frameNext = firstCycle;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < 4; i++) begin
                hold[i] <= '0;
            end
            oZ     <= '0;
            oS0    <= 1'b0;
            oS1    <= 1'b0;
            oFrame <= 1'b0;
            oValid <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                hold[i] <= holdNext[i];
            end
            oZ     <= zNext;
            oS0    <= selNext[0];
            oS1    <= selNext[1];
            oFrame <= frameNext;
            oValid <= validNext;
        end
    end

endmodule
